// File: rtl/vend_dispenser.sv
// vend_dispenser: actuator-side companion to the vending controller.
// Queues prod/change strobes in saturating pending counters and drives the
// product motor and the coin hopper one request at a time, each with a
// done-sensor handshake. Product is always served before change.
// Optional macro VEND_DISP_TIMEOUT_EN enables a per-actuation watchdog that
// latches a sticky fault; clr_fault leaves FAULT and retries the request.
module vend_dispenser #(
    parameter int CNT_W       = 3,
    parameter int TIMEOUT_CYC = 32,
    parameter int GAP_CYC     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod,
    input  logic             change,
    input  logic             motor_done,
    input  logic             hopper_ack,
    input  logic             clr_fault,
    output logic             motor_on,
    output logic             hopper_on,
    output logic             busy,
    output logic             fault,
    output logic             ovf,
    output logic [CNT_W-1:0] prod_pend,
    output logic [CNT_W-1:0] chg_pend
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE,
        S_GAP,
        S_FAULT
    } state_t;

    localparam int GAP_W = $clog2(GAP_CYC + 1) + 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] prod_q, prod_d, chg_q, chg_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ovf_q, ovf_d;
    logic             prod_dec, chg_dec;

`ifdef VEND_DISP_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             fault_q;
`else
    // Watchdog is compiled out: keep the otherwise-unused inputs referenced.
    logic unused_cfg;
    assign unused_cfg = clr_fault ^ (TIMEOUT_CYC == 0);
`endif

    // Next-state logic, completion decrements and the GAP/watchdog timers.
    always_comb begin
        state_n  = state;
        gap_d    = gap_q;
        prod_dec = 1'b0;
        chg_dec  = 1'b0;
`ifdef VEND_DISP_TIMEOUT_EN
        tmr_d    = tmr_q;
`endif
        case (state)
            S_IDLE: begin
                gap_d = '0;
`ifdef VEND_DISP_TIMEOUT_EN
                tmr_d = '0;
`endif
                if (prod_q != '0)
                    state_n = S_VEND;
                else if (chg_q != '0)
                    state_n = S_CHANGE;
            end
            S_VEND: begin
                gap_d = '0;
                // Sensor on the timeout edge wins over the watchdog.
                if (motor_done) begin
                    prod_dec = 1'b1;
                    state_n  = S_GAP;
                end
`ifdef VEND_DISP_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1))
                    state_n = S_FAULT;
                else
                    tmr_d = tmr_q + 1'b1;
`endif
            end
            S_CHANGE: begin
                gap_d = '0;
                if (hopper_ack) begin
                    chg_dec = 1'b1;
                    state_n = S_GAP;
                end
`ifdef VEND_DISP_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1))
                    state_n = S_FAULT;
                else
                    tmr_d = tmr_q + 1'b1;
`endif
            end
            S_GAP: begin
                // The completion cycle plus GAP_CYC settle cycles, so IDLE is
                // reached GAP_CYC+1 edges after the sensor was sampled.
                if (gap_q == GAP_W'(GAP_CYC)) begin
                    state_n = S_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_FAULT: begin
`ifdef VEND_DISP_TIMEOUT_EN
                if (clr_fault)
                    state_n = S_IDLE;
`else
                state_n = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Saturating pending counters; simultaneous inc and dec cancel.
    always_comb begin
        prod_d = prod_q;
        chg_d  = chg_q;
        ovf_d  = ovf_q;
        if (prod && !prod_dec) begin
            if (prod_q == '1)
                ovf_d = 1'b1;
            else
                prod_d = prod_q + 1'b1;
        end else if (!prod && prod_dec) begin
            prod_d = prod_q - 1'b1;
        end
        if (change && !chg_dec) begin
            if (chg_q == '1)
                ovf_d = 1'b1;
            else
                chg_d = chg_q + 1'b1;
        end else if (!change && chg_dec) begin
            chg_d = chg_q - 1'b1;
        end
    end

    // State, counters and registered outputs; reset drops drives at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prod_q    <= '0;
            chg_q     <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            motor_on  <= 1'b0;
            hopper_on <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            prod_q    <= prod_d;
            chg_q     <= chg_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_d;
            motor_on  <= (state_n == S_VEND);
            hopper_on <= (state_n == S_CHANGE);
            busy      <= (state_n != S_IDLE) || (prod_d != '0) || (chg_d != '0);
        end
    end

`ifdef VEND_DISP_TIMEOUT_EN
    // Watchdog timer and sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            fault_q <= (state_n == S_FAULT);
        end
    end
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign ovf       = ovf_q;
    assign prod_pend = prod_q;
    assign chg_pend  = chg_q;

endmodule
